// File: rtl/spi_host_fifo_window.sv
// Register-window bridge from TX/RX bus windows to a pair of SPI host FIFOs.
// Each window runs its own IDLE/WAIT/RESP FSM with an optional FIFO wait timeout.
module spi_host_fifo_window #(
  parameter int          DataWidth     = 32,
  parameter int          AddrWidth     = 6,
  parameter int unsigned TxOffset      = 32'h24,
  parameter int unsigned RxOffset      = 32'h24,
  parameter int          TimeoutCycles = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   tx_valid_i,
  input  logic                   tx_write_i,
  input  logic [AddrWidth-1:0]   tx_addr_i,
  input  logic [DataWidth-1:0]   tx_wdata_i,
  input  logic [DataWidth/8-1:0] tx_wstrb_i,
  output logic                   tx_ready_o,
  output logic                   tx_error_o,
  output logic [DataWidth-1:0]   tx_rdata_o,
  input  logic                   rx_valid_i,
  input  logic                   rx_write_i,
  input  logic [AddrWidth-1:0]   rx_addr_i,
  output logic                   rx_ready_o,
  output logic                   rx_error_o,
  output logic [DataWidth-1:0]   rx_rdata_o,
  output logic                   txf_valid_o,
  output logic [DataWidth-1:0]   txf_data_o,
  output logic [DataWidth/8-1:0] txf_be_o,
  input  logic                   txf_ready_i,
  input  logic                   rxf_valid_i,
  input  logic [DataWidth-1:0]   rxf_data_i,
  output logic                   rxf_ready_o,
  output logic                   tx_timeout_o,
  output logic                   rx_timeout_o
);

  localparam int StrbWidth = DataWidth / 8;
  localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam bit TimeoutEn = (TimeoutCycles > 32'sd0);
  localparam logic [AddrWidth-1:0] TxAddr = AddrWidth'(TxOffset);
  localparam logic [AddrWidth-1:0] RxAddr = AddrWidth'(RxOffset);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]           tx_state_q, tx_state_d;
  logic [DataWidth-1:0] tx_data_q, tx_data_d;
  logic [StrbWidth-1:0] tx_strb_q, tx_strb_d;
  logic                 tx_err_q, tx_err_d;
  logic                 tx_to_q, tx_to_d;
  logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;

  logic [1:0]           rx_state_q, rx_state_d;
  logic [DataWidth-1:0] rx_rdata_q, rx_rdata_d;
  logic                 rx_err_q, rx_err_d;
  logic                 rx_to_q, rx_to_d;
  logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;

  // TX window next-state: classify request, then wait for push or timeout
  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    tx_strb_d  = tx_strb_q;
    tx_err_d   = tx_err_q;
    tx_cnt_d   = tx_cnt_q;
    tx_to_d    = 1'b0;
    case (tx_state_q)
      StIdle: begin
        if (tx_valid_i) begin
          tx_data_d = tx_wdata_i;
          tx_strb_d = tx_wstrb_i;
          tx_cnt_d  = {CntW{1'b0}};
          if (!tx_write_i || (tx_addr_i != TxAddr)) begin
            tx_err_d   = 1'b1;
            tx_state_d = StResp;
          end else if (tx_wstrb_i == {StrbWidth{1'b0}}) begin
            tx_err_d   = 1'b0;
            tx_state_d = StResp;
          end else begin
            tx_err_d   = 1'b0;
            tx_state_d = StWait;
          end
        end else begin
          tx_state_d = StIdle;
        end
      end
      StWait: begin
        if (txf_ready_i) begin
          tx_err_d   = 1'b0;
          tx_state_d = StResp;
        end else if (TimeoutEn && (tx_cnt_q == CntMax)) begin
          tx_err_d   = 1'b1;
          tx_to_d    = 1'b1;
          tx_state_d = StResp;
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1'b1);
        end
      end
      StResp:  tx_state_d = StIdle;
      default: tx_state_d = StIdle;
    endcase
  end

  // RX window next-state: classify request, then wait for pop or timeout
  always_comb begin
    rx_state_d = rx_state_q;
    rx_rdata_d = rx_rdata_q;
    rx_err_d   = rx_err_q;
    rx_cnt_d   = rx_cnt_q;
    rx_to_d    = 1'b0;
    case (rx_state_q)
      StIdle: begin
        if (rx_valid_i) begin
          rx_cnt_d   = {CntW{1'b0}};
          rx_rdata_d = {DataWidth{1'b0}};
          if (rx_write_i || (rx_addr_i != RxAddr)) begin
            rx_err_d   = 1'b1;
            rx_state_d = StResp;
          end else begin
            rx_err_d   = 1'b0;
            rx_state_d = StWait;
          end
        end else begin
          rx_state_d = StIdle;
        end
      end
      StWait: begin
        if (rxf_valid_i) begin
          rx_rdata_d = rxf_data_i;
          rx_err_d   = 1'b0;
          rx_state_d = StResp;
        end else if (TimeoutEn && (rx_cnt_q == CntMax)) begin
          rx_rdata_d = {DataWidth{1'b0}};
          rx_err_d   = 1'b1;
          rx_to_d    = 1'b1;
          rx_state_d = StResp;
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1'b1);
        end
      end
      StResp:  rx_state_d = StIdle;
      default: rx_state_d = StIdle;
    endcase
  end

  // State and data registers for both windows
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tx_state_q <= StIdle;
      tx_data_q  <= {DataWidth{1'b0}};
      tx_strb_q  <= {StrbWidth{1'b0}};
      tx_err_q   <= 1'b0;
      tx_to_q    <= 1'b0;
      tx_cnt_q   <= {CntW{1'b0}};
      rx_state_q <= StIdle;
      rx_rdata_q <= {DataWidth{1'b0}};
      rx_err_q   <= 1'b0;
      rx_to_q    <= 1'b0;
      rx_cnt_q   <= {CntW{1'b0}};
    end else begin
      tx_state_q <= tx_state_d;
      tx_data_q  <= tx_data_d;
      tx_strb_q  <= tx_strb_d;
      tx_err_q   <= tx_err_d;
      tx_to_q    <= tx_to_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_state_q <= rx_state_d;
      rx_rdata_q <= rx_rdata_d;
      rx_err_q   <= rx_err_d;
      rx_to_q    <= rx_to_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

  // Outputs decode straight from registers; data is zeroed outside its valid phase
  assign txf_valid_o  = (tx_state_q == StWait);
  assign txf_data_o   = txf_valid_o ? tx_data_q : {DataWidth{1'b0}};
  assign txf_be_o     = txf_valid_o ? tx_strb_q : {StrbWidth{1'b0}};
  assign tx_ready_o   = (tx_state_q == StResp);
  assign tx_error_o   = tx_ready_o & tx_err_q;
  assign tx_timeout_o = tx_to_q;
  assign tx_rdata_o   = {DataWidth{1'b0}};

  assign rxf_ready_o  = (rx_state_q == StWait);
  assign rx_ready_o   = (rx_state_q == StResp);
  assign rx_error_o   = rx_ready_o & rx_err_q;
  assign rx_rdata_o   = rx_ready_o ? rx_rdata_q : {DataWidth{1'b0}};
  assign rx_timeout_o = rx_to_q;

endmodule

// File: tb/tb_spi_host_fifo_window.sv
// Directed and randomized bench for spi_host_fifo_window against a transaction-level model.
module tb_spi_host_fifo_window;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        tx_valid_i, tx_write_i;
  logic [5:0]  tx_addr_i;
  logic [31:0] tx_wdata_i;
  logic [3:0]  tx_wstrb_i;
  logic        tx_ready_o, tx_error_o;
  logic [31:0] tx_rdata_o;
  logic        rx_valid_i, rx_write_i;
  logic [5:0]  rx_addr_i;
  logic        rx_ready_o, rx_error_o;
  logic [31:0] rx_rdata_o;
  logic        txf_valid_o;
  logic [31:0] txf_data_o;
  logic [3:0]  txf_be_o;
  logic        txf_ready_i, rxf_valid_i;
  logic [31:0] rxf_data_i;
  logic        rxf_ready_o, tx_timeout_o, rx_timeout_o;

  spi_host_fifo_window dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .tx_valid_i(tx_valid_i), .tx_write_i(tx_write_i), .tx_addr_i(tx_addr_i),
    .tx_wdata_i(tx_wdata_i), .tx_wstrb_i(tx_wstrb_i),
    .tx_ready_o(tx_ready_o), .tx_error_o(tx_error_o), .tx_rdata_o(tx_rdata_o),
    .rx_valid_i(rx_valid_i), .rx_write_i(rx_write_i), .rx_addr_i(rx_addr_i),
    .rx_ready_o(rx_ready_o), .rx_error_o(rx_error_o), .rx_rdata_o(rx_rdata_o),
    .txf_valid_o(txf_valid_o), .txf_data_o(txf_data_o), .txf_be_o(txf_be_o),
    .txf_ready_i(txf_ready_i), .rxf_valid_i(rxf_valid_i), .rxf_data_i(rxf_data_i),
    .rxf_ready_o(rxf_ready_o), .tx_timeout_o(tx_timeout_o), .rx_timeout_o(rx_timeout_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // Transaction-level model: a pending request, its acceptance edge, and a due response
  int          edge_n = 0;
  bit          m_tx_pend, m_tx_resp, m_tx_err, m_tx_to;
  int          m_tx_acc;
  logic [31:0] m_tx_data;
  logic [3:0]  m_tx_strb;
  bit          m_rx_pend, m_rx_resp, m_rx_err, m_rx_to;
  int          m_rx_acc;
  logic [31:0] m_rx_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model_step();
    bit legal;
    edge_n++;
    if (!rst_ni) begin
      m_tx_pend = 1'b0; m_tx_resp = 1'b0; m_tx_err = 1'b0; m_tx_to = 1'b0;
      m_rx_pend = 1'b0; m_rx_resp = 1'b0; m_rx_err = 1'b0; m_rx_to = 1'b0;
      m_rx_rd = 32'h0;
      return;
    end
    if (m_tx_resp) m_tx_resp = 1'b0;
    else if (m_tx_pend) begin
      if (txf_ready_i) begin
        m_tx_pend = 1'b0; m_tx_resp = 1'b1; m_tx_err = 1'b0; m_tx_to = 1'b0;
      end else if (TO != 0 && edge_n - m_tx_acc == TO) begin
        m_tx_pend = 1'b0; m_tx_resp = 1'b1; m_tx_err = 1'b1; m_tx_to = 1'b1;
      end
    end else if (tx_valid_i) begin
      legal = tx_write_i && (tx_addr_i == 6'h24);
      if (legal && tx_wstrb_i != 4'h0) begin
        m_tx_pend = 1'b1; m_tx_acc = edge_n; m_tx_data = tx_wdata_i; m_tx_strb = tx_wstrb_i;
      end else begin
        m_tx_resp = 1'b1; m_tx_err = !legal; m_tx_to = 1'b0;
      end
    end
    if (m_rx_resp) m_rx_resp = 1'b0;
    else if (m_rx_pend) begin
      if (rxf_valid_i) begin
        m_rx_pend = 1'b0; m_rx_resp = 1'b1; m_rx_err = 1'b0; m_rx_to = 1'b0; m_rx_rd = rxf_data_i;
      end else if (TO != 0 && edge_n - m_rx_acc == TO) begin
        m_rx_pend = 1'b0; m_rx_resp = 1'b1; m_rx_err = 1'b1; m_rx_to = 1'b1; m_rx_rd = 32'h0;
      end
    end else if (rx_valid_i) begin
      if (!rx_write_i && rx_addr_i == 6'h24) begin
        m_rx_pend = 1'b1; m_rx_acc = edge_n;
      end else begin
        m_rx_resp = 1'b1; m_rx_err = 1'b1; m_rx_to = 1'b0; m_rx_rd = 32'h0;
      end
    end
  endtask

  task automatic compare_all();
    chk("tx_ready", tx_ready_o, m_tx_resp);
    chk("tx_error", tx_error_o, m_tx_resp && m_tx_err);
    chk("tx_timeout", tx_timeout_o, m_tx_resp && m_tx_to);
    chk("tx_rdata", tx_rdata_o, 32'h0);
    chk("txf_valid", txf_valid_o, m_tx_pend);
    if (m_tx_pend) begin
      chk("txf_data", txf_data_o, m_tx_data);
      chk("txf_be", txf_be_o, m_tx_strb);
    end
    chk("rx_ready", rx_ready_o, m_rx_resp);
    chk("rx_error", rx_error_o, m_rx_resp && m_rx_err);
    chk("rx_timeout", rx_timeout_o, m_rx_resp && m_rx_to);
    chk("rxf_ready", rxf_ready_o, m_rx_pend);
    if (m_rx_resp) chk("rx_rdata", rx_rdata_o, m_rx_rd);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int hi;
    rst_ni = 1'b0;
    tx_valid_i = 1'b0; tx_write_i = 1'b0; tx_addr_i = 6'h0; tx_wdata_i = 32'h0; tx_wstrb_i = 4'h0;
    rx_valid_i = 1'b0; rx_write_i = 1'b0; rx_addr_i = 6'h0;
    txf_ready_i = 1'b0; rxf_valid_i = 1'b0; rxf_data_i = 32'h0;
    step();
    step();
    chk("reset_txf_valid", txf_valid_o, 1'b0);
    chk("reset_tx_ready", tx_ready_o, 1'b0);
    chk("reset_rx_ready", rx_ready_o, 1'b0);
    chk("reset_rxf_ready", rxf_ready_o, 1'b0);

    // Legal write sampled on the first edge out of reset, FIFO ready
    rst_ni = 1'b1;
    tx_valid_i = 1'b1; tx_write_i = 1'b1; tx_addr_i = 6'h24; tx_wdata_i = 32'hDEADBEEF; tx_wstrb_i = 4'hF;
    txf_ready_i = 1'b1;
    step();
    tx_valid_i = 1'b0;
    chk("w_push_valid", txf_valid_o, 1'b1);
    chk("w_push_data", txf_data_o, 32'hDEADBEEF);
    chk("w_early_ready", tx_ready_o, 1'b0);
    step();
    chk("w_ready", tx_ready_o, 1'b1);
    chk("w_error", tx_error_o, 1'b0);
    chk("w_push_once", txf_valid_o, 1'b0);
    step();

    // Read on TX window, then write to the wrong address
    tx_valid_i = 1'b1; tx_write_i = 1'b0; tx_addr_i = 6'h24;
    step();
    tx_valid_i = 1'b0;
    chk("txrd_ready", tx_ready_o, 1'b1);
    chk("txrd_error", tx_error_o, 1'b1);
    chk("txrd_nopush", txf_valid_o, 1'b0);
    step();
    tx_valid_i = 1'b1; tx_write_i = 1'b1; tx_addr_i = 6'h20;
    step();
    tx_valid_i = 1'b0;
    chk("txbad_ready", tx_ready_o, 1'b1);
    chk("txbad_error", tx_error_o, 1'b1);
    chk("txbad_nopush", txf_valid_o, 1'b0);
    step();

    // RX read stalled three cycles
    rx_valid_i = 1'b1; rx_write_i = 1'b0; rx_addr_i = 6'h24; rxf_valid_i = 1'b0;
    step();
    rx_valid_i = 1'b0;
    hi = 0;
    for (int i = 0; i < 3; i++) begin
      hi += int'(rxf_ready_o);
      step();
    end
    hi += int'(rxf_ready_o);
    rxf_valid_i = 1'b1; rxf_data_i = 32'h12345678;
    step();
    rxf_valid_i = 1'b0;
    chk("rx_pop_cycles", hi, 4);
    chk("rx_stall_ready", rx_ready_o, 1'b1);
    chk("rx_stall_data", rx_rdata_o, 32'h12345678);
    step();

    // Timeout with FIFO never ready, then handshake in the last allowed cycle
    for (int pass = 0; pass < 2; pass++) begin
      txf_ready_i = 1'b0;
      tx_valid_i = 1'b1; tx_write_i = 1'b1; tx_addr_i = 6'h24; tx_wdata_i = 32'hA5A5_0000 + pass; tx_wstrb_i = 4'h3;
      step();
      tx_valid_i = 1'b0;
      hi = 0;
      while (txf_valid_o && hi < 40) begin
        hi++;
        if (pass == 1 && hi == TO) txf_ready_i = 1'b1;
        step();
      end
      txf_ready_i = 1'b0;
      chk("to_valid_cycles", hi, TO);
      chk("to_ready", tx_ready_o, 1'b1);
      chk("to_error", tx_error_o, (pass == 0) ? 1'b1 : 1'b0);
      chk("to_pulse", tx_timeout_o, (pass == 0) ? 1'b1 : 1'b0);
      step();
      chk("to_pulse_width", tx_timeout_o, 1'b0);
    end

    // Reset during RX wait abandons the read; a later read completes
    rx_valid_i = 1'b1; rx_write_i = 1'b0; rx_addr_i = 6'h24; rxf_valid_i = 1'b0;
    step();
    rx_valid_i = 1'b0;
    step();
    rst_ni = 1'b0;
    step();
    chk("rst_pop", rxf_ready_o, 1'b0);
    chk("rst_resp", rx_ready_o, 1'b0);
    rst_ni = 1'b1;
    step();
    chk("rst_no_late_resp", rx_ready_o, 1'b0);
    rx_valid_i = 1'b1; rxf_valid_i = 1'b1; rxf_data_i = 32'hCAFEF00D;
    step();
    rx_valid_i = 1'b0;
    step();
    chk("post_rst_ready", rx_ready_o, 1'b1);
    chk("post_rst_data", rx_rdata_o, 32'hCAFEF00D);
    rxf_valid_i = 1'b0;
    step();

    // Concurrent TX write and RX read
    tx_valid_i = 1'b1; tx_write_i = 1'b1; tx_addr_i = 6'h24; tx_wdata_i = 32'h0BADF00D; tx_wstrb_i = 4'hF;
    rx_valid_i = 1'b1; rx_write_i = 1'b0; rx_addr_i = 6'h24;
    txf_ready_i = 1'b1; rxf_valid_i = 1'b1; rxf_data_i = 32'h87654321;
    step();
    tx_valid_i = 1'b0; rx_valid_i = 1'b0;
    chk("cc_push_data", txf_data_o, 32'h0BADF00D);
    step();
    chk("cc_tx_ready", tx_ready_o, 1'b1);
    chk("cc_rx_ready", rx_ready_o, 1'b1);
    chk("cc_rx_data", rx_rdata_o, 32'h87654321);
    txf_ready_i = 1'b0; rxf_valid_i = 1'b0;
    step();

    // Randomized traffic; slow phases force timeouts
    for (int c = 0; c < 4000; c++) begin
      int slow;
      slow = ((c / 500) % 2 == 1) ? 30 : 2;
      rst_ni      = ($urandom_range(0, 299) != 0);
      tx_valid_i  = ($urandom_range(0, 2) == 0);
      tx_write_i  = ($urandom_range(0, 4) != 0);
      tx_addr_i   = ($urandom_range(0, 3) != 0) ? 6'h24 : 6'($urandom);
      tx_wdata_i  = $urandom;
      tx_wstrb_i  = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
      rx_valid_i  = ($urandom_range(0, 2) == 0);
      rx_write_i  = ($urandom_range(0, 4) == 0);
      rx_addr_i   = ($urandom_range(0, 3) != 0) ? 6'h24 : 6'($urandom);
      txf_ready_i = ($urandom_range(0, slow) == 0);
      rxf_valid_i = ($urandom_range(0, slow) == 0);
      rxf_data_i  = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/spi_host_fifo_window.md
SPI_HOST_FIFO_WINDOW -- requirements
Module: spi_host_fifo_window

Interface
REQ-001 SHALL have parameter DataWidth, default 32: bus and FIFO data width, a multiple of 8 in the range 8..64.
REQ-002 SHALL have parameter AddrWidth, default 6: window address width.
REQ-003 SHALL have parameters TxOffset and RxOffset, defaults 'h24 and 'h24: the only legal addresses on the TX and RX windows.
REQ-004 SHALL have parameter TimeoutCycles, default 16: maximum FIFO wait in cycles; 0 disables the timeout.
REQ-005 SHALL have ports, as name direction width meaning:
 clk_i  in  1  single clock, rising edge.
 rst_ni  in  1  reset; synchronous and active-low.
 tx_valid_i tx_write_i  in  1 each  TX window request valid and write.
 tx_addr_i  in  AddrWidth  TX request address.
 tx_wdata_i  in  DataWidth  TX write data.
 tx_wstrb_i  in  DataWidth/8  TX byte strobes.
 tx_ready_o tx_error_o  out  1 each  TX response ready and error.
 tx_rdata_o  out  DataWidth  TX read data; always 0.
 rx_valid_i rx_write_i  in  1 each  RX window request valid and write.
 rx_addr_i  in  AddrWidth  RX request address.
 rx_ready_o rx_error_o  out  1 each  RX response ready and error.
 rx_rdata_o  out  DataWidth  RX read data.
 txf_valid_o  out  1  push valid to the TX FIFO.
 txf_data_o  out  DataWidth  push data.
 txf_be_o  out  DataWidth/8  push byte enables.
 txf_ready_i  in  1  TX FIFO accepts a push.
 rxf_valid_i  in  1  RX FIFO has data.
 rxf_data_i  in  DataWidth  RX FIFO head.
 rxf_ready_o  out  1  pop request to the RX FIFO.
 tx_timeout_o rx_timeout_o  out  1 each  one-cycle pulse when a timeout abort occurs.

Function
REQ-006 SHALL run two independent FSMs, TX and RX, each with the states IDLE, WAIT and RESP.
REQ-007 TX IDLE: when tx_valid_i is high, SHALL latch write, address, wdata and wstrb, then move as follows:
 to WAIT if the request is a legal write (tx_write_i=1, address=TxOffset, wstrb≠0);
 to RESP with error=1 if the request is a read or has any other address;
 to RESP with error=0 and no push if the request is a legal write with wstrb=0.
REQ-008 TX WAIT: SHALL drive txf_valid_o=1 with the latched data and strobes; these SHALL stay stable until the handshake.
 On txf_ready_i=1 the FSM SHALL go to RESP with error=0.
REQ-009 RX IDLE: when rx_valid_i is high, SHALL move to WAIT for a read to RxOffset.
 Any write, or any other address, SHALL move to RESP with error=1 and rdata=0.
REQ-010 RX WAIT: SHALL drive rxf_ready_o=1.
 On rxf_valid_i=1 the FSM SHALL register rxf_data_i into the rdata register and go to RESP with error=0.
REQ-011 RESP: SHALL assert the window ready output for exactly one cycle, with the registered error and rdata, then return to IDLE.
 At all other times ready SHALL be 0 and error SHALL be 0.
REQ-012 A new request SHALL be sampled in IDLE only; a request still held high in the IDLE cycle after RESP SHALL be treated as a new transaction.
REQ-013 Latency: request sampled in cycle N, FIFO handshake in N+1 -> ready in N+2; each stall cycle adds one cycle.
REQ-014 Timeout counter: SHALL be cleared on entry to WAIT and increment on each WAIT cycle without a handshake.
 When it equals TimeoutCycles-1 with no handshake, the FSM SHALL go to RESP with error=1 (rdata=0 for RX) and pulse the matching timeout output for one cycle.
REQ-015 A handshake in the final allowed cycle SHALL complete normally, with no timeout.
REQ-016 With TimeoutCycles=0, WAIT SHALL persist until the handshake.
REQ-017 txf_valid_o SHALL be high for at most TimeoutCycles consecutive cycles per request, and rxf_ready_o likewise.
REQ-018 Simultaneous TX and RX activity SHALL proceed independently, with no arbitration.
REQ-019 At most one FIFO push or pop SHALL occur per accepted request.

Reset
REQ-020 When rst_ni=0 at a rising edge, both FSMs SHALL enter IDLE, counters SHALL clear and the rdata register SHALL clear.
 All outputs SHALL be 0 from that edge on.
REQ-021 Reset during WAIT or RESP SHALL abandon the transaction: no ready response and no further push or pop.
REQ-022 The first request SHALL be sampled at the first rising edge with rst_ni=1.

Verification
REQ-023 TX write 'hDEADBEEF, strb 'hF, to 'h24, txf_ready_i=1 -> txf_valid_o high 1 cycle with that data; tx_ready_o=1, error=0, 2 cycles after sampling.
REQ-024 RX read of 'h24 with rxf_valid_i low for 3 cycles, then rxf_data_i='h12345678 -> rxf_ready_o high 4 cycles; rx_rdata_o='h12345678 with rx_ready_o.
REQ-025 TX read, or TX write to 'h20 -> no push; tx_ready_o=1 with error=1, 1 cycle after sampling.
REQ-026 TimeoutCycles=16, txf_ready_i=0 throughout -> txf_valid_o high 16 cycles; tx_timeout_o pulse; error=1.
 Repeat with txf_ready_i=1 in the 16th cycle -> error=0, no pulse.
REQ-027 rst_ni=0 during RX WAIT -> rxf_ready_o=0 and rx_ready_o=0 from that edge.
 A new read after reset completes normally.
REQ-028 Concurrent TX write and RX read with both FIFOs ready -> both respond in the same cycle with correct data.
